// File: rtl/bram_18_pkg.sv
// bram_18_pkg: shared widths for the asymmetric byte-write / word-read block RAM
package bram_18_pkg;
  localparam int ADDRA_W = 11;
  localparam int DINA_W  = 8;
  localparam int ADDRB_W = 9;
  localparam int DOUTB_W = 32;
  localparam int LANES   = 4;
endpackage

// File: rtl/bram_lane.sv
// bram_lane: 512 x 8 RAM bank with a write port and a read-first registered read port
module bram_lane
  import bram_18_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [ADDRB_W-1:0] waddr,
  input  logic [DINA_W-1:0]  din,
  input  logic               en,
  input  logic [ADDRB_W-1:0] raddr,
  output logic [DINA_W-1:0]  dout
);
  logic [DINA_W-1:0] mem [2**ADDRB_W];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= din;
    if (en) dout <= mem[raddr];
  end
endmodule

// File: rtl/bram_18.sv
// bram_18: 2048x8 write port, 512x32 read port over four byte-lane banks
module bram_18
  import bram_18_pkg::*;
(
  input  logic               clka,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [0:0]         wea,
  input  logic [ADDRA_W-1:0] addra,
  input  logic [DINA_W-1:0]  dina,
  input  logic               enb,
  input  logic [ADDRB_W-1:0] addrb,
  output logic [DOUTB_W-1:0] doutb
);
  logic [DINA_W-1:0] lane_q [LANES];
  logic valid;
  // valid masks the bank registers so the output clears asynchronously without resetting RAM
  always_ff @(posedge clka or negedge rst_n)
    if (!rst_n) valid <= 1'b0;
    else if (enb) valid <= 1'b1;
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    bram_lane u_lane (
      .clk  (clka),
      .we   (rst_n & ena & wea[0] & (addra[1:0] == 2'(k))),
      .waddr(addra[ADDRA_W-1:2]),
      .din  (dina),
      .en   (rst_n & enb),
      .raddr(addrb),
      .dout (lane_q[k])
    );
  end
  assign doutb = valid ? {lane_q[3], lane_q[2], lane_q[1], lane_q[0]} : '0;
endmodule

// File: tb/tb_bram_18.sv
// tb_bram_18: directed scoreboard bench for bram_18 against a byte-array model
module tb_bram_18;
  logic        clka = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic [0:0]  wea = 1'b0;
  logic [10:0] addra = '0;
  logic [7:0]  dina = '0;
  logic        enb = 1'b0;
  logic [8:0]  addrb = '0;
  logic [31:0] doutb;
  logic [7:0]  model [2048];
  logic [31:0] sb [$];
  logic [31:0] last = '0;
  int total = 0;
  int bad = 0;
  bram_18 dut (
    .clka(clka), .rst_n(rst_n), .ena(ena), .wea(wea), .addra(addra),
    .dina(dina), .enb(enb), .addrb(addrb), .doutb(doutb)
  );
  always #5 clka = ~clka;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input string tag, input logic e_a, input logic w_a, input logic [10:0] a,
                     input logic [7:0] d, input logic e_b, input logic [8:0] b);
    logic [31:0] exp;
    ena = e_a; wea = w_a; addra = a; dina = d; enb = e_b; addrb = b;
    if (e_b) sb.push_back({model[{b, 2'd3}], model[{b, 2'd2}], model[{b, 2'd1}], model[{b, 2'd0}]});
    if (e_a && w_a) model[a] = d;
    @(posedge clka); #1;
    if (e_b) begin
      exp = sb.pop_front();
      last = exp;
    end else exp = last;
    chk(tag, doutb, exp);
    ena = 1'b0; wea = 1'b0; enb = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 2048; i++) model[i] = 8'h00;
    #2 chk("reset_value", doutb, 32'h0);
    @(posedge clka); #1 chk("reset_held", doutb, 32'h0);
    @(negedge clka) rst_n = 1'b1;
    @(posedge clka); #1;
    cyc("wr0", 1, 1, 11'd0, 8'h11, 0, 9'd0);
    cyc("wr1", 1, 1, 11'd1, 8'h22, 0, 9'd0);
    cyc("wr2", 1, 1, 11'd2, 8'h33, 0, 9'd0);
    cyc("wr3", 1, 1, 11'd3, 8'h44, 0, 9'd0);
    cyc("pack", 0, 0, 11'd0, 8'h00, 1, 9'd0);
    chk("pack_const", doutb, 32'h44332211);
    for (int k = 0; k < 9; k++) cyc("stride_wr", 1, 1, 11'(4 * (k + 1)), 8'(8'hD0 + k), 0, 9'd0);
    for (int k = 0; k < 9; k++) begin
      cyc("stride_rd", 0, 0, 11'd0, 8'h00, 1, 9'(k + 1));
      chk("stride_const", doutb, 32'(8'hD0 + k));
    end
    cyc("ena0_wr", 0, 1, 11'd8, 8'h55, 0, 9'd0);
    cyc("wea0_wr", 1, 0, 11'd8, 8'h66, 0, 9'd0);
    cyc("en_rd", 0, 0, 11'd0, 8'h00, 1, 9'd2);
    chk("en_const", doutb, 32'h000000D1);
    cyc("enb0_hold_a", 0, 0, 11'd0, 8'h00, 0, 9'd5);
    cyc("enb0_hold_b", 0, 0, 11'd0, 8'h00, 0, 9'd0);
    cyc("coll_pre", 0, 0, 11'd0, 8'h00, 1, 9'd0);
    cyc("coll_same", 1, 1, 11'd1, 8'hAA, 1, 9'd0);
    chk("coll_old", doutb, 32'h44332211);
    cyc("coll_next", 0, 0, 11'd0, 8'h00, 1, 9'd0);
    chk("coll_new", doutb, 32'h4433AA11);
    cyc("top_wr", 1, 1, 11'd2047, 8'hFF, 0, 9'd0);
    cyc("top_rd", 0, 0, 11'd0, 8'h00, 1, 9'd511);
    chk("top_byte", doutb, 32'hFF000000);
    cyc("nowrap", 0, 0, 11'd0, 8'h00, 1, 9'd0);
    #2 rst_n = 1'b0;
    #1 chk("async_clear", doutb, 32'h0);
    ena = 1'b1; wea = 1'b1; addra = 11'd0; dina = 8'h99; enb = 1'b1; addrb = 9'd0;
    @(posedge clka); #1 chk("reset_ignore", doutb, 32'h0);
    ena = 1'b0; wea = 1'b0; enb = 1'b0;
    @(negedge clka) rst_n = 1'b1;
    @(posedge clka); #1 chk("post_reset_idle", doutb, 32'h0);
    cyc("survive", 0, 0, 11'd0, 8'h00, 1, 9'd0);
    chk("survive_const", doutb, 32'h4433AA11);
    cyc("survive_top", 0, 0, 11'd0, 8'h00, 1, 9'd511);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
